// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite compositor.
// Sprites are 8x8 ROM pixels drawn at 2x scale; one line RAM entry holds a 2-px pair.
package sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_CHECK,
    ST_FETCH
  } state_t;

  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 8;
  localparam int SCALE    = 2;
  localparam int ENTRY_W  = 8;
  localparam int PIX_W    = 2;
  localparam logic [PIX_W-1:0] TRANSPARENT = 2'b00;

endpackage

// File: rtl/sprite_hit_check.sv
// Decides whether a sprite covers the row being built and where its pixels land.
// Row distance is modular so sprites near y=1023 wrap onto the top rows.
module sprite_hit_check
  import sprite_pkg::*;
(
  input  logic [9:0]         row,
  input  logic [9:0]         attr_y,
  input  logic [9:0]         attr_x,
  input  logic               en,
  output logic               hit,
  output logic [2:0]         srow,
  output logic [ENTRY_W-1:0] base
);

  logic [9:0] dy;
  logic       unused_x;

  assign dy       = row - attr_y;
  assign hit      = en && (dy < 10'(SPRITE_H * SCALE));
  assign srow     = dy[3:1];
  // Entry = pixel pair, so x bit 0 drops out; bit 9 falls off the 256-entry half.
  assign base     = attr_x[8:1];
  assign unused_x = attr_x[9] ^ attr_x[0];

endmodule

// File: rtl/sprite_line_sched.sv
// Builds one sprite scanline: clears the back half of the line RAM, then walks the
// attribute table from the highest index down, fetching 8 ROM pixels per hit.
module sprite_line_sched
  import sprite_pkg::*;
#(
  parameter  int NUM_SPRITES  = 8,
  parameter  int HALF_ENTRIES = 256,
  localparam int IDX_W        = $clog2(NUM_SPRITES)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Line_Start,
  input  logic [9:0]       i_Next_Row,
  input  logic             i_Buf_Sel,
  output logic [IDX_W-1:0] o_Attr_Addr,
  input  logic             i_Attr_En,
  input  logic [9:0]       i_Attr_X,
  input  logic [9:0]       i_Attr_Y,
  input  logic [5:0]       i_Attr_Num,
  output logic [5:0]       o_Rom_Sprite,
  output logic [2:0]       o_Rom_Row,
  output logic [2:0]       o_Rom_Col,
  input  logic [PIX_W-1:0] i_Rom_Pixel,
  output logic             o_Lr_Write,
  output logic [10:0]      o_Lr_Addr,
  output logic [PIX_W-1:0] o_Lr_Data,
  output logic             o_Busy,
  output logic             o_Line_Done,
  output logic             o_Overrun
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   index, index_n;
  logic [9:0]         row, row_n;
  logic               half, half_n;
  logic [ENTRY_W-1:0] ccnt, ccnt_n;
  logic [3:0]         fcnt, fcnt_n;
  logic [ENTRY_W-1:0] base, base_n;
  logic [5:0]         rom_sprite_n;
  logic [2:0]         rom_row_n, rom_col_n;
  logic               lr_write_n;
  logic [10:0]        lr_addr_n;
  logic [PIX_W-1:0]   lr_data_n;
  logic               done_n, overrun_n;

  logic               hit;
  logic [2:0]         hit_srow;
  logic [ENTRY_W-1:0] hit_base;
  logic [ENTRY_W-1:0] fetch_entry;

  sprite_hit_check u_hit (
    .row    (row),
    .attr_y (i_Attr_Y),
    .attr_x (i_Attr_X),
    .en     (i_Attr_En),
    .hit    (hit),
    .srow   (hit_srow),
    .base   (hit_base)
  );

  // Pixel arriving now belongs to the column requested one cycle earlier.
  assign fetch_entry = base + ENTRY_W'(fcnt) - ENTRY_W'(1);
  assign o_Attr_Addr = index;
  assign o_Busy      = (state != ST_IDLE);

  always_comb begin
    state_n      = state;
    index_n      = index;
    row_n        = row;
    half_n       = half;
    ccnt_n       = ccnt;
    fcnt_n       = fcnt;
    base_n       = base;
    rom_sprite_n = o_Rom_Sprite;
    rom_row_n    = o_Rom_Row;
    rom_col_n    = o_Rom_Col;
    lr_write_n   = 1'b0;
    lr_addr_n    = '0;
    lr_data_n    = '0;
    done_n       = 1'b0;
    overrun_n    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_Line_Start) begin
          row_n   = i_Next_Row;
          half_n  = i_Buf_Sel;
          ccnt_n  = '0;
          state_n = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        lr_write_n = 1'b1;
        lr_addr_n  = {2'b00, half, ccnt};
        ccnt_n     = ccnt + ENTRY_W'(1);
        if (ccnt == ENTRY_W'(HALF_ENTRIES - 1)) begin
          index_n = IDX_W'(NUM_SPRITES - 1);
          state_n = ST_SCAN;
        end
      end
      ST_SCAN: state_n = ST_CHECK;
      ST_CHECK: begin
        if (hit) begin
          rom_sprite_n = i_Attr_Num;
          rom_row_n    = hit_srow;
          rom_col_n    = 3'd0;
          base_n       = hit_base;
          fcnt_n       = 4'd0;
          state_n      = ST_FETCH;
        end else if (index == '0) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          index_n = index - IDX_W'(1);
          state_n = ST_SCAN;
        end
      end
      ST_FETCH: begin
        if (fcnt < 4'(SPRITE_W - 1)) rom_col_n = fcnt[2:0] + 3'd1;
        if (fcnt != 4'd0 && i_Rom_Pixel != TRANSPARENT) begin
          lr_write_n = 1'b1;
          lr_addr_n  = {2'b00, half, fetch_entry};
          lr_data_n  = i_Rom_Pixel;
        end
        fcnt_n = fcnt + 4'd1;
        if (fcnt == 4'(SPRITE_W)) begin
          if (index == '0) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            index_n = index - IDX_W'(1);
            state_n = ST_SCAN;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A new line start while busy abandons the current build outright.
    if (i_Line_Start && state != ST_IDLE) begin
      overrun_n  = 1'b1;
      done_n     = 1'b0;
      row_n      = i_Next_Row;
      half_n     = i_Buf_Sel;
      ccnt_n     = '0;
      fcnt_n     = 4'd0;
      lr_write_n = 1'b0;
      lr_addr_n  = '0;
      lr_data_n  = '0;
      state_n    = ST_CLEAR;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      row          <= '0;
      half         <= 1'b0;
      ccnt         <= '0;
      fcnt         <= '0;
      base         <= '0;
      o_Rom_Sprite <= '0;
      o_Rom_Row    <= '0;
      o_Rom_Col    <= '0;
      o_Lr_Write   <= 1'b0;
      o_Lr_Addr    <= '0;
      o_Lr_Data    <= '0;
      o_Line_Done  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      state        <= state_n;
      index        <= index_n;
      row          <= row_n;
      half         <= half_n;
      ccnt         <= ccnt_n;
      fcnt         <= fcnt_n;
      base         <= base_n;
      o_Rom_Sprite <= rom_sprite_n;
      o_Rom_Row    <= rom_row_n;
      o_Rom_Col    <= rom_col_n;
      o_Lr_Write   <= lr_write_n;
      o_Lr_Addr    <= lr_addr_n;
      o_Lr_Data    <= lr_data_n;
      o_Line_Done  <= done_n;
      o_Overrun    <= overrun_n;
    end
  end

endmodule
